// File: rtl/int16_to_fp16_enc.sv
// rtl/int16_to_fp16_enc.sv - 16-bit integer to IEEE-754 half-precision encoder
//
// Purpose:
//   Converts one 16-bit integer at a time into fp16 (1 sign, 5 exp bias 15,
//   10 mantissa) with round-to-nearest-even. The integer is normalised by a
//   small FSM (IDLE -> NORM -> ROUND -> DONE). Zero goes straight to DONE.
//   Results feed the half-precision add/sub unit.
//
// Parameters:
//   SIGNED_IN  1: in_data is two's complement; 0: in_data is unsigned
//
// Configuration macro:
//   I2F_FAST_NORM_EN  defined: NORM takes a single cycle (priority encoder
//                     plus barrel shift); undefined: NORM shifts one bit per
//                     cycle. Both builds produce identical results.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data valid
//   in_ready   out  encoder can accept (IDLE only)
//   in_data    in   integer to convert
//   out_valid  out  out_data holds a result (DONE)
//   out_ready  in   consumer accepts out_data
//   out_data   out  fp16 result
//   busy       out  high in every state except IDLE

module int16_to_fp16_enc #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state;
  logic        sign;
  logic [15:0] mag;
  logic [4:0]  exp_q;
  logic [15:0] result;

  // Input magnitude; -32768 negates to 16'h8000, which is the correct
  // unsigned magnitude.
  logic        in_neg;
  logic [15:0] in_mag;

  assign in_neg = SIGNED_IN && in_data[15];
  assign in_mag = in_neg ? (~in_data + 16'd1) : in_data;

  // Rounding on the normalised magnitude (mag[15] is the hidden one).
  logic [9:0]  mant;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [10:0] mant_sum;
  logic [4:0]  exp_rnd;
  logic [15:0] rnd_result;

  assign mant       = mag[14:5];
  assign guard_bit  = mag[4];
  assign sticky_bit = |mag[3:0];
  assign round_up   = guard_bit && (sticky_bit || mant[0]);
  assign mant_sum   = {1'b0, mant} + {10'd0, round_up};
  // exp_q is at most 30, so a mantissa carry can reach 31 but cannot wrap.
  assign exp_rnd    = exp_q + {4'd0, mant_sum[10]};

  always_comb begin
    rnd_result = {sign, exp_rnd, mant_sum[9:0]};
    if (exp_rnd == 5'd31) begin
      rnd_result = {sign, 5'h1F, 10'h000};
    end
  end

`ifdef I2F_FAST_NORM_EN
  // Leading-zero count of a nonzero magnitude.
  function automatic logic [3:0] count_lz(input logic [15:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        n = 4'(15 - i);
      end
    end
    return n;
  endfunction

  logic [3:0] norm_lz;
  assign norm_lz = count_lz(mag);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sign   <= 1'b0;
      mag    <= 16'h0000;
      exp_q  <= 5'd0;
      result <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign  <= in_neg;
            mag   <= in_mag;
            exp_q <= 5'd30;
            if (in_mag == 16'h0000) begin
              // Zero is always +0, whatever the sign of the input.
              result <= 16'h0000;
              state  <= ST_DONE;
            end else begin
              state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
`ifdef I2F_FAST_NORM_EN
          mag   <= mag << norm_lz;
          exp_q <= 5'd30 - {1'b0, norm_lz};
          state <= ST_ROUND;
`else
          if (mag[15]) begin
            state <= ST_ROUND;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - 5'd1;
          end
`endif
        end
        ST_ROUND: begin
          result <= rnd_result;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = result;

endmodule
